// File: rtl/cnn_stream_pkg.sv
// Shared register map, control/status bit positions and FSM state type for the
// streaming 1-D convolution engine.
package cnn_stream_pkg;

    localparam logic [7:0] RegCtrl       = 8'h00;
    localparam logic [7:0] RegStatus     = 8'h04;
    localparam logic [7:0] RegLen        = 8'h08;
    localparam logic [7:0] RegShift      = 8'h0C;
    localparam logic [7:0] RegBias       = 8'h10;
    localparam logic [7:0] RegOutCount   = 8'h14;

    localparam int unsigned CtrlStart     = 0;
    localparam int unsigned CtrlRelu      = 1;
    localparam int unsigned CtrlClearDone = 2;
    localparam int unsigned CtrlAbort     = 3;

    localparam int unsigned StatBusy   = 0;
    localparam int unsigned StatDone   = 1;
    localparam int unsigned StatSat    = 2;
    localparam int unsigned StatLenErr = 3;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/cnn_conv_stream_if.sv
// Bus bundle for the convolution engine: OBI register port, sample in/out
// streams and the done level.
interface cnn_conv_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         obi_req;
    logic                         obi_gnt;
    logic [31:0]                  obi_addr;
    logic                         obi_we;
    logic [31:0]                  obi_wdata;
    logic                         obi_rvalid;
    logic [31:0]                  obi_rdata;
    logic                         obi_err;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         done;

    modport slave (
        input  obi_req, obi_addr, obi_we, obi_wdata, in_valid, in_data, out_ready,
        output obi_gnt, obi_rvalid, obi_rdata, obi_err, in_ready, out_valid, out_data, done
    );

    modport master (
        output obi_req, obi_addr, obi_we, obi_wdata, in_valid, in_data, out_ready,
        input  obi_gnt, obi_rvalid, obi_rdata, obi_err, in_ready, out_valid, out_data, done
    );
endinterface

// File: rtl/cnn_requant.sv
// Requantiser: arithmetic right shift, optional ReLU, saturation to the sample
// width. sat_o flags any clipping.
module cnn_requant #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    input  logic        [4:0]            shift_i,
    input  logic                         relu_en_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         sat_o
);
    localparam logic signed [ACC_WIDTH-1:0] MaxVal = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MinVal = ~MaxVal;

    logic signed [ACC_WIDTH-1:0] shifted;

    // Shift (floor), clamp negatives under ReLU, then clip to output range
    always_comb begin
        shifted = acc_i >>> shift_i;
        if (relu_en_i && shifted < 0) begin
            shifted = '0;
        end
        sat_o = 1'b0;
        if (shifted > MaxVal) begin
            data_o = MaxVal[DATA_WIDTH-1:0];
            sat_o  = 1'b1;
        end else if (shifted < MinVal) begin
            data_o = MinVal[DATA_WIDTH-1:0];
            sat_o  = 1'b1;
        end else begin
            data_o = shifted[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/cnn_conv_stream.sv
// Streaming 1-D convolution engine: OBI-configured kernel sliding over an input
// sample stream, one requantised output per sample once the window is full.
module cnn_conv_stream
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TAPS   = 9,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    cnn_conv_stream_if.slave  bus
);
    localparam int FillW = $clog2(NUM_TAPS);

    state_e                       state_q, state_d;
    logic                         relu_en_q, relu_en_d, sat_seen_q, sat_seen_d;
    logic                         len_err_q, len_err_d;
    logic [LEN_WIDTH-1:0]         len_q, len_d, out_cnt_q, out_cnt_d, issued_q, issued_d;
    logic [4:0]                   shift_q, shift_d;
    logic signed [ACC_WIDTH-1:0]  bias_q, bias_d;
    logic signed [DATA_WIDTH-1:0] weight_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] weight_d [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] win_q    [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] win_d    [NUM_TAPS];
    logic [FillW-1:0]             fill_q, fill_d;
    logic                         rvalid_q, rvalid_d, err_q, err_d, out_valid_q, out_valid_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic signed [DATA_WIDTH-1:0]   taps [NUM_TAPS];
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [DATA_WIDTH-1:0]   rq_data;
    logic                           rq_sat;

    logic [7:0]           addr;
    logic                 busy, in_ready, in_fire, out_fire, ctrl_wr;
    logic                 start, clear_done, abort, w_hit;
    logic [3:0]           w_idx;
    logic [LEN_WIDTH-1:0] due;
    logic                 unused_bits;

    assign unused_bits = ^{bus.obi_addr[31:8], bus.obi_wdata[31:ACC_WIDTH]};

    assign addr     = bus.obi_addr[7:0];
    assign busy     = (state_q == StFill) || (state_q == StRun);
    assign due      = len_q - LEN_WIDTH'(NUM_TAPS - 1);
    assign in_ready = (state_q == StFill) ||
                      ((state_q == StRun) && (!out_valid_q || bus.out_ready) && (issued_q < due));
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign ctrl_wr    = bus.obi_req && bus.obi_we && (addr == RegCtrl);
    assign start      = ctrl_wr && bus.obi_wdata[CtrlStart];
    assign clear_done = ctrl_wr && bus.obi_wdata[CtrlClearDone];
    assign abort      = ctrl_wr && bus.obi_wdata[CtrlAbort];
    assign w_idx      = addr[5:2];
    assign w_hit      = (addr[7:6] == 2'b01) && (addr[1:0] == 2'b00) &&
                        ({1'b0, w_idx} < 5'(NUM_TAPS));

    assign bus.obi_gnt    = bus.obi_req && !rst_i;
    assign bus.obi_rvalid = rvalid_q;
    assign bus.obi_rdata  = rdata_q;
    assign bus.obi_err    = err_q;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.done       = (state_q == StDone);

    // Window as it looks after accepting the current sample; x[0] is oldest
    always_comb begin
        prod = '0;
        acc  = bias_q;
        for (int i = 0; i < NUM_TAPS - 1; i++) begin
            taps[i] = win_q[i+1];
        end
        taps[NUM_TAPS-1] = bus.in_data;
        for (int i = 0; i < NUM_TAPS; i++) begin
            prod = weight_q[i] * taps[i];
            acc  = acc + ACC_WIDTH'(prod);
        end
    end

    cnn_requant #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_requant (
        .acc_i    (acc),
        .shift_i  (shift_q),
        .relu_en_i(relu_en_q),
        .data_o   (rq_data),
        .sat_o    (rq_sat)
    );

    // Register-port decode plus FSM and datapath next state
    always_comb begin
        state_d     = state_q;
        relu_en_d   = relu_en_q;
        sat_seen_d  = sat_seen_q;
        len_err_d   = len_err_q;
        len_d       = len_q;
        out_cnt_d   = out_cnt_q;
        issued_d    = issued_q;
        shift_d     = shift_q;
        bias_d      = bias_q;
        weight_d    = weight_q;
        win_d       = win_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rvalid_d    = bus.obi_req;
        err_d       = 1'b0;
        rdata_d     = '0;

        if (bus.obi_req) begin
            case (addr)
                RegCtrl: begin
                    if (!bus.obi_we) begin
                        rdata_d[CtrlRelu] = relu_en_q;
                    end else if (!busy) begin
                        relu_en_d = bus.obi_wdata[CtrlRelu];
                    end
                end
                RegStatus: begin
                    if (bus.obi_we) err_d = 1'b1;
                    else rdata_d = {28'b0, len_err_q, sat_seen_q, state_q == StDone, busy};
                end
                RegLen: begin
                    if (!bus.obi_we) rdata_d = 32'(len_q);
                    else if (busy) err_d = 1'b1;
                    else len_d = bus.obi_wdata[LEN_WIDTH-1:0];
                end
                RegShift: begin
                    if (!bus.obi_we) rdata_d = 32'(shift_q);
                    else if (busy) err_d = 1'b1;
                    else shift_d = bus.obi_wdata[4:0];
                end
                RegBias: begin
                    if (!bus.obi_we) rdata_d = 32'(bias_q);
                    else if (busy) err_d = 1'b1;
                    else bias_d = bus.obi_wdata[ACC_WIDTH-1:0];
                end
                RegOutCount: begin
                    if (bus.obi_we) err_d = 1'b1;
                    else rdata_d = 32'(out_cnt_q);
                end
                default: begin
                    if (!w_hit || (bus.obi_we && busy)) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_TAPS; i++) begin
                            if (w_idx == 4'(i)) begin
                                if (bus.obi_we) weight_d[i] = bus.obi_wdata[DATA_WIDTH-1:0];
                                else rdata_d = 32'(weight_q[i]);
                            end
                        end
                    end
                end
            endcase
        end

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (len_q < LEN_WIDTH'(NUM_TAPS)) begin
                        len_err_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        len_err_d  = 1'b0;
                        sat_seen_d = 1'b0;
                        out_cnt_d  = '0;
                        issued_d   = '0;
                        fill_d     = '0;
                        state_d    = StFill;
                    end
                end else if (clear_done && state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StFill: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end else if (in_fire) begin
                    win_d  = taps;
                    fill_d = fill_q + FillW'(1);
                    if (fill_q == FillW'(NUM_TAPS - 2)) state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    if (out_fire) begin
                        out_valid_d = 1'b0;
                        out_cnt_d   = out_cnt_q + LEN_WIDTH'(1);
                        if (out_cnt_q + LEN_WIDTH'(1) == due) state_d = StDone;
                    end
                    if (in_fire) begin
                        win_d       = taps;
                        out_valid_d = 1'b1;
                        out_data_d  = rq_data;
                        sat_seen_d  = sat_seen_q | rq_sat;
                        issued_d    = issued_q + LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and register storage, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            relu_en_q   <= 1'b0;
            sat_seen_q  <= 1'b0;
            len_err_q   <= 1'b0;
            len_q       <= '0;
            out_cnt_q   <= '0;
            issued_q    <= '0;
            shift_q     <= '0;
            bias_q      <= '0;
            fill_q      <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                weight_q[i] <= '0;
                win_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            relu_en_q   <= relu_en_d;
            sat_seen_q  <= sat_seen_d;
            len_err_q   <= len_err_d;
            len_q       <= len_d;
            out_cnt_q   <= out_cnt_d;
            issued_q    <= issued_d;
            shift_q     <= shift_d;
            bias_q      <= bias_d;
            fill_q      <= fill_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < NUM_TAPS; i++) begin
                weight_q[i] <= weight_d[i];
                win_q[i]    <= win_d[i];
            end
        end
    end
endmodule

// File: tb/tb_cnn_conv_stream.sv
// Directed bench for cnn_conv_stream: register access, runs, requantisation,
// saturation, backpressure, errors, abort and asynchronous reset.
module tb_cnn_conv_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic signed [7:0] samples [16];
    logic signed [7:0] got [$];

    cnn_conv_stream_if #(.DATA_WIDTH(8)) bus ();

    cnn_conv_stream #(
        .DATA_WIDTH(8),
        .NUM_TAPS  (9),
        .ACC_WIDTH (24),
        .LEN_WIDTH (16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic obi_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        @(negedge clk);
        bus.obi_req   = 1'b1;
        bus.obi_we    = we;
        bus.obi_addr  = addr;
        bus.obi_wdata = wdata;
        #1;
        check("gnt", 32'(bus.obi_gnt), 32'd1);
        @(negedge clk);
        bus.obi_req = 1'b0;
        bus.obi_we  = 1'b0;
        #1;
        check("rvalid", 32'(bus.obi_rvalid), 32'd1);
        rdata = bus.obi_rdata;
        err   = bus.obi_err;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_err);
        logic [31:0] rd_v;
        logic        e;
        obi_xfer(1'b1, addr, data, rd_v, e);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        check({tag, "_wr_rdata"}, rd_v, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                      input logic exp_err);
        logic [31:0] rd_v;
        logic        e;
        obi_xfer(1'b0, addr, 32'd0, rd_v, e);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        if (!exp_err) check(tag, rd_v, exp);
    endtask

    // Feed n samples and collect outputs until done, stalling out_ready for a window
    task automatic run_stream(input string tag, input int n, input int stall_at,
                              input int stall_len);
        int                si = 0;
        int                cyc = 0;
        int                stalls = 0;
        logic              held_v = 1'b0;
        logic signed [7:0] held = '0;
        got.delete();
        while (!bus.done && cyc < 200) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            bus.in_valid  = (si < n);
            bus.in_data   = (si < n) ? samples[si] : '0;
            #1;
            if (held_v) begin
                check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, "_hold_data"}, 32'(bus.out_data), 32'(held));
            end
            held_v = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
                stalls++;
                held_v = 1'b1;
                held   = bus.out_data;
            end
            if (bus.in_valid && bus.in_ready) si++;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            cyc++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_consumed"}, 32'(si), 32'(n));
        if (stall_len > 0) check({tag, "_stall_seen"}, 32'(stalls > 0), 32'd1);
    endtask

    task automatic feed_n(input int n, input logic ready);
        int si = 0;
        int cyc = 0;
        bus.out_ready = ready;
        while (si < n && cyc < 100) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = samples[si];
            #1;
            if (bus.in_ready) si++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("feed_count", 32'(si), 32'(n));
    endtask

    task automatic expect_outs(input string tag, input int e0, input int e1, input int cnt);
        check({tag, "_count"}, 32'(got.size()), 32'(cnt));
        if (got.size() > 0) check({tag, "_out0"}, 32'(got[0]), 32'(e0));
        if (got.size() > 1 && cnt > 1) check({tag, "_out1"}, 32'(got[1]), 32'(e1));
    endtask

    task automatic set_weights(input logic [31:0] w);
        for (int i = 0; i < 9; i++) wr("wr_weight", 32'h40 + 32'(4 * i), w, 1'b0);
    endtask

    task automatic ramp();
        for (int i = 0; i < 16; i++) samples[i] = 8'(i + 1);
    endtask

    initial begin
        bus.obi_req = 0; bus.obi_we = 0; bus.obi_addr = 0; bus.obi_wdata = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;
        #1;
        check("rst_gnt", 32'(bus.obi_gnt), 32'd0);
        check("rst_rvalid", 32'(bus.obi_rvalid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd("rst_status", 32'h04, 32'h0, 1'b0);
        rd("rst_outcnt", 32'h14, 32'h0, 1'b0);

        // Basic run
        ramp();
        set_weights(32'd1);
        wr("len", 32'h08, 32'd10, 1'b0);
        wr("start", 32'h00, 32'h1, 1'b0);
        run_stream("basic", 10, 1000, 0);
        expect_outs("basic", 45, 54, 2);
        rd("basic_outcnt", 32'h14, 32'd2, 1'b0);
        rd("basic_status", 32'h04, 32'h2, 1'b0);

        // Requantisation without and with ReLU
        wr("shift", 32'h0C, 32'd2, 1'b0);
        wr("bias", 32'h10, 32'hFFFF_FFA6, 1'b0);
        rd("bias_rd", 32'h10, 32'hFFFF_FFA6, 1'b0);
        wr("start_rq", 32'h00, 32'h1, 1'b0);
        run_stream("rq", 10, 1000, 0);
        expect_outs("rq", -12, -9, 2);
        wr("start_relu", 32'h00, 32'h3, 1'b0);
        run_stream("relu", 10, 1000, 0);
        expect_outs("relu", 0, 0, 2);
        rd("ctrl_rd", 32'h00, 32'h2, 1'b0);

        // Saturation both ways
        set_weights(32'd127);
        wr("shift0", 32'h0C, 32'd0, 1'b0);
        wr("bias0", 32'h10, 32'd0, 1'b0);
        wr("len9", 32'h08, 32'd9, 1'b0);
        for (int i = 0; i < 16; i++) samples[i] = 8'sd127;
        wr("start_satp", 32'h00, 32'h1, 1'b0);
        run_stream("satp", 9, 1000, 0);
        expect_outs("satp", 127, 0, 1);
        rd("satp_status", 32'h04, 32'h6, 1'b0);
        rd("weight_sext", 32'h40, 32'h7F, 1'b0);
        for (int i = 0; i < 16; i++) samples[i] = -8'sd128;
        wr("start_satn", 32'h00, 32'h1, 1'b0);
        run_stream("satn", 9, 1000, 0);
        expect_outs("satn", -128, 0, 1);
        rd("satn_status", 32'h04, 32'h6, 1'b0);

        // Backpressure mid-run
        ramp();
        set_weights(32'd1);
        wr("len10", 32'h08, 32'd10, 1'b0);
        wr("start_bp", 32'h00, 32'h1, 1'b0);
        run_stream("bp", 10, 9, 5);
        expect_outs("bp", 45, 54, 2);
        rd("bp_status", 32'h04, 32'h2, 1'b0);

        // Errors
        rd("unmapped", 32'h3C, 32'h0, 1'b1);
        wr("ro_status", 32'h04, 32'h1, 1'b1);
        wr("len5", 32'h08, 32'd5, 1'b0);
        wr("start_short", 32'h00, 32'h1, 1'b0);
        rd("len_err_status", 32'h04, 32'h8, 1'b0);
        wr("len10b", 32'h08, 32'd10, 1'b0);

        // Abort after 4 samples, busy write rejected, then a clean run
        wr("start_ab", 32'h00, 32'h1, 1'b0);
        feed_n(4, 1'b1);
        wr("busy_weight", 32'h40, 32'd5, 1'b1);
        wr("busy_start", 32'h00, 32'h1, 1'b0);
        rd("busy_status", 32'h04, 32'h1, 1'b0);
        wr("abort", 32'h00, 32'h8, 1'b0);
        rd("abort_status", 32'h04, 32'h0, 1'b0);
        check("abort_done", 32'(bus.done), 32'd0);
        rd("weight_kept", 32'h40, 32'h1, 1'b0);
        wr("start_after", 32'h00, 32'h1, 1'b0);
        run_stream("after", 10, 1000, 0);
        expect_outs("after", 45, 54, 2);
        wr("clear_done", 32'h00, 32'h4, 1'b0);
        rd("cleared_status", 32'h04, 32'h0, 1'b0);

        // Asynchronous reset in RUN with an output pending
        wr("start_rst", 32'h00, 32'h1, 1'b0);
        feed_n(9, 1'b0);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_data", 32'(bus.out_data), 32'd45);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_data", 32'(bus.out_data), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        rd("arst_weight", 32'h40, 32'h0, 1'b0);
        rd("arst_len", 32'h08, 32'h0, 1'b0);
        rd("arst_status", 32'h04, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
